// File: rtl/ethernet_header_rx_pkg.sv
// Shared types and constants for the Ethernet header receiver: FSM states,
// header layout offsets and the beat record carried through the output buffer.
package eth_pkg;

  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DROP} rx_state_e;

  localparam logic [15:0] ETHERTYPE_GALAPAGOS = 16'h7400;
  localparam logic [47:0] MAC_BCAST           = 48'hFFFF_FFFF_FFFF;
  localparam logic [7:0]  KEEP_FULL           = 8'hFF;

  // Wire-byte offsets within the two header beats
  localparam int OFF_DST    = 0;  // beat 0, 6 bytes
  localparam int OFF_SRC_HI = 6;  // beat 0, 2 bytes
  localparam int OFF_SRC_LO = 0;  // beat 1, 4 bytes
  localparam int OFF_TYPE   = 4;  // beat 1, 2 bytes
  localparam int OFF_DEST   = 6;  // beat 1, 1 byte

  // Sideband travels with every payload beat so that dest/src change exactly
  // when a new frame's first beat reaches the output.
  typedef struct packed {
    logic [7:0]  dest;
    logic [47:0] src;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  function automatic logic [7:0] wire_byte(input logic [63:0] data, input int k);
    return data[8*k +: 8];
  endfunction

  function automatic logic [15:0] get_be16(input logic [63:0] data, input int k);
    return {wire_byte(data, k), wire_byte(data, k + 1)};
  endfunction

  function automatic logic [31:0] get_be32(input logic [63:0] data, input int k);
    return {get_be16(data, k), get_be16(data, k + 2)};
  endfunction

  function automatic logic [47:0] get_be48(input logic [63:0] data, input int k);
    return {get_be16(data, k), get_be32(data, k + 2)};
  endfunction

endpackage

// File: rtl/ethernet_header_rx_if.sv
// 64-bit AXI-Stream style beat bus with keep/last and a valid/ready handshake.
interface ethernet_header_rx_if;
  logic [63:0] data;
  logic [7:0]  keep;
  logic        last;
  logic        valid;
  logic        ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ethernet_header_rx_axis_skid_buffer.sv
// Two-entry skid buffer: registered output plus one overflow slot, with the
// upstream ready taken straight from a flop.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_fire;

  assign in_ready_o  = !skid_vld_q;
  assign out_data_o  = main_q;
  assign out_valid_o = main_vld_q;
  assign in_fire     = in_valid_i && !skid_vld_q;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_ready_i) begin
      // Output slot frees up: refill from the skid slot first to keep order
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: rtl/ethernet_header_rx.sv
// Parses a two-beat Ethernet/Galapagos header, filters on MAC and ethertype,
// and forwards payload beats with the frame's dest byte and source MAC.
module ethernet_header_rx
  import eth_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE    = ETHERTYPE_GALAPAGOS,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [47:0]                 local_mac_addr,
  ethernet_header_rx_if.slave         stream_in,
  ethernet_header_rx_if.master        stream_out,
  output logic [7:0]                  stream_out_dest,
  output logic [47:0]                 src_mac_addr,
  output logic [31:0]                 frames_ok,
  output logic [31:0]                 frames_dropped
);

  rx_state_e   state_q;
  logic        run_q;
  logic [31:0] ok_q, drop_q;
  logic [47:0] dst_q, local_q;
  logic [15:0] src_hi_q;
  logic [31:0] src_lo_q;
  logic [7:0]  dest_q;

  logic        in_fire, hdr_full, addr_hit, hdr1_match;
  logic        buf_in_valid, buf_in_ready, buf_out_valid;
  beat_t       push_beat, head_beat;

  // run_q holds ready low while in reset and for the first edge after release
  assign stream_in.ready = run_q && ((state_q != PAYLOAD) || buf_in_ready);
  assign in_fire         = stream_in.valid && stream_in.ready;
  assign hdr_full        = (stream_in.keep == KEEP_FULL);
  assign addr_hit        = (dst_q == local_q) || (ACCEPT_BCAST && (dst_q == MAC_BCAST));
  assign hdr1_match      = addr_hit && (get_be16(stream_in.data, OFF_TYPE) == ETHERTYPE) && hdr_full;
  assign buf_in_valid    = run_q && stream_in.valid && (state_q == PAYLOAD);

  always_comb begin
    push_beat      = '0;
    push_beat.dest = dest_q;
    push_beat.src  = {src_hi_q, src_lo_q};
    push_beat.last = stream_in.last;
    push_beat.keep = stream_in.keep;
    push_beat.data = stream_in.data;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= HDR0;
      run_q   <= 1'b0;
      ok_q    <= '0;
      drop_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (in_fire) begin
        unique case (state_q)
          HDR0: begin
            if (stream_in.last || !hdr_full) begin
              drop_q  <= drop_q + 32'd1;
              state_q <= stream_in.last ? HDR0 : DROP;
            end else begin
              state_q <= HDR1;
            end
          end
          HDR1: begin
            // A matching header with last set carries no payload and is dropped too
            if (!hdr1_match || stream_in.last) begin
              drop_q  <= drop_q + 32'd1;
              state_q <= stream_in.last ? HDR0 : DROP;
            end else begin
              state_q <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (stream_in.last) begin
              ok_q    <= ok_q + 32'd1;
              state_q <= HDR0;
            end
          end
          DROP: begin
            if (stream_in.last) state_q <= HDR0;
          end
          default: state_q <= HDR0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && (state_q == HDR0)) begin
      dst_q    <= get_be48(stream_in.data, OFF_DST);
      src_hi_q <= get_be16(stream_in.data, OFF_SRC_HI);
      local_q  <= local_mac_addr;
    end
    if (in_fire && (state_q == HDR1) && hdr1_match && !stream_in.last) begin
      dest_q   <= wire_byte(stream_in.data, OFF_DEST);
      src_lo_q <= get_be32(stream_in.data, OFF_SRC_LO);
    end
  end

  axis_skid_buffer #(
    .WIDTH($bits(beat_t))
  ) u_out_buf (
    .clk         (clk),
    .aresetn     (aresetn),
    .in_data_i   (push_beat),
    .in_valid_i  (buf_in_valid),
    .in_ready_o  (buf_in_ready),
    .out_data_o  (head_beat),
    .out_valid_o (buf_out_valid),
    .out_ready_i (stream_out.ready)
  );

  assign stream_out.data  = head_beat.data;
  assign stream_out.keep  = head_beat.keep;
  assign stream_out.last  = head_beat.last;
  assign stream_out.valid = buf_out_valid;
  assign stream_out_dest  = head_beat.dest;
  assign src_mac_addr     = head_beat.src;
  assign frames_ok        = ok_q;
  assign frames_dropped   = drop_q;

endmodule

// File: tb/tb_ethernet_header_rx.sv
// Randomised bench for ethernet_header_rx with a frame-level reference model.
module tb_ethernet_header_rx;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [47:0] local_mac_addr;
  logic [7:0]  stream_out_dest;
  logic [47:0] src_mac_addr;
  logic [31:0] frames_ok, frames_dropped;

  ethernet_header_rx_if in_if ();
  ethernet_header_rx_if out_if ();

  ethernet_header_rx dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .local_mac_addr (local_mac_addr),
    .stream_in      (in_if),
    .stream_out     (out_if),
    .stream_out_dest(stream_out_dest),
    .src_mac_addr   (src_mac_addr),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  dest;
    logic [47:0] src;
  } obeat_t;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [7:0]  dest;
    int          nhdr;
    int          npay;
    logic [7:0]  last_keep;
  } frame_t;

  obeat_t exp_q[$];
  obeat_t rx_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     stall_viol = 0;
  int     exp_ok = 0;
  int     exp_drop = 0;
  bit     rnd_ready = 1'b0;

  obeat_t hp_beat;
  bit     hp_v = 1'b0;
  bit     hp_r = 1'b0;

  always @(posedge clk) begin
    #1;
    out_if.ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge clk) begin
    obeat_t cur;
    cur = {out_if.data, out_if.keep, out_if.last, stream_out_dest, src_mac_addr};
    if (aresetn && out_if.valid && out_if.ready) rx_q.push_back(cur);
    if (aresetn && hp_v && !hp_r && (cur !== hp_beat || !out_if.valid)) stall_viol++;
    hp_v    = aresetn && out_if.valid;
    hp_r    = out_if.ready;
    hp_beat = cur;
  end

  function automatic frame_t mk_frame(input logic [47:0] dst, input logic [47:0] src,
                                      input logic [15:0] etype, input logic [7:0] dest,
                                      input int nhdr, input int npay, input logic [7:0] lk);
    frame_t f;
    f.dst = dst; f.src = src; f.etype = etype; f.dest = dest;
    f.nhdr = nhdr; f.npay = npay; f.last_keep = lk;
    return f;
  endfunction

  // Frame-level acceptance rule: complete header, at least one payload beat,
  // addressed to us (or broadcast) and carrying the Galapagos ethertype.
  function automatic bit model_accept(input frame_t f);
    return (f.nhdr == 2) && (f.npay > 0) &&
           ((f.dst == local_mac_addr) || (f.dst == 48'hFFFF_FFFF_FFFF)) &&
           (f.etype == 16'h7400);
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           output int waits);
    bit acc;
    in_if.data  = d;
    in_if.keep  = k;
    in_if.last  = l;
    in_if.valid = 1'b1;
    waits = 0;
    acc   = 1'b0;
    while (!acc) begin
      acc = in_if.ready;
      @(posedge clk);
      @(negedge clk);
      if (!acc) begin
        waits++;
        if (waits > 2000) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_accept_timeout: waited %0d cycles, required acceptance", waits);
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic send_frame(input frame_t f, input int abort_at, output int hdr_wait);
    logic [63:0] d;
    logic [7:0]  k;
    int          w;
    bit          acc;
    obeat_t      ob;
    acc = model_accept(f);
    d = {f.src[39:32], f.src[47:40], f.dst[7:0], f.dst[15:8],
         f.dst[23:16], f.dst[31:24], f.dst[39:32], f.dst[47:40]};
    send_beat(d, 8'hFF, f.nhdr == 1, hdr_wait);
    if (f.nhdr == 2) begin
      d = {8'($urandom()), f.dest, f.etype[7:0], f.etype[15:8],
           f.src[7:0], f.src[15:8], f.src[23:16], f.src[31:24]};
      send_beat(d, 8'hFF, f.npay == 0, w);
      for (int i = 0; i < f.npay; i++) begin
        d = {$urandom(), $urandom()};
        k = 8'hFF;
        if (i == f.npay - 1) k = (f.last_keep != 8'h00) ? f.last_keep : 8'($urandom_range(1, 255));
        if (i == abort_at) begin
          in_if.data = d; in_if.keep = k; in_if.last = (i == f.npay - 1); in_if.valid = 1'b1;
          return;
        end
        ob = {d, k, (i == f.npay - 1), f.dest, f.src};
        if (acc) exp_q.push_back(ob);
        send_beat(d, k, i == f.npay - 1, w);
      end
    end
    if (acc) exp_ok++;
    else exp_drop++;
  endtask

  task automatic wait_drain(output bit to);
    int n = 0;
    in_if.valid = 1'b0;
    while (rx_q.size() < exp_q.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    to = (rx_q.size() < exp_q.size());
    repeat (6) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_if.valid = 1'b0;
    aresetn     = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rx_q.delete();
    exp_ok   = 0;
    exp_drop = 0;
    aresetn  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_if.ready); end
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_if.valid); end
    n_checks++; if (frames_ok !== 32'd0) begin n_fail++; $display("FAIL reset_frames_ok: got %0d expected 0", frames_ok); end
    n_checks++; if (frames_dropped !== 32'd0) begin n_fail++; $display("FAIL reset_frames_dropped: got %0d expected 0", frames_dropped); end
    n_checks++; if (stream_out_dest !== 8'd0) begin n_fail++; $display("FAIL reset_dest: got %h expected 00", stream_out_dest); end
    n_checks++; if (src_mac_addr !== 48'd0) begin n_fail++; $display("FAIL reset_src_mac: got %h expected 0", src_mac_addr); end
    apply_reset();
  endtask

  task automatic test_basic();
    int w; bit to;
    apply_reset();
    local_mac_addr = 48'h0A0B_0C0D_0E0F;
    send_frame(mk_frame(48'h0A0B_0C0D_0E0F, 48'h1122_3344_5566, 16'h7400, 8'h05, 2, 3, 8'h0F), -1, w);
    wait_drain(to);
    n_checks++; if (to || rx_q.size() != 3) begin n_fail++; $display("FAIL basic_beat_count: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_beat%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (rx_q.size() == 3 && rx_q[2].keep !== 8'h0F) begin n_fail++; $display("FAIL basic_last_keep: got %h expected 0f", rx_q[2].keep); end
    n_checks++; if (stream_out_dest !== 8'h05) begin n_fail++; $display("FAIL basic_dest: got %h expected 05", stream_out_dest); end
    n_checks++; if (src_mac_addr !== 48'h1122_3344_5566) begin n_fail++; $display("FAIL basic_src_mac: got %h expected 112233445566", src_mac_addr); end
    n_checks++; if (frames_ok !== 32'd1) begin n_fail++; $display("FAIL basic_frames_ok: got %0d expected 1", frames_ok); end
  endtask

  task automatic test_mismatch();
    int w; bit to;
    apply_reset();
    local_mac_addr = 48'h0A0B_0C0D_0E0F;
    send_frame(mk_frame(48'h0A0B_0C0D_0E00, 48'h1122_3344_5566, 16'h7400, 8'h05, 2, 3, 8'h0F), -1, w);
    send_frame(mk_frame(48'h0A0B_0C0D_0E0F, 48'h6655_4433_2211, 16'h7400, 8'h09, 2, 2, 8'h00), -1, w);
    n_checks++; if (w != 0) begin n_fail++; $display("FAIL mismatch_no_bubble: header waited %0d cycles, expected 0", w); end
    wait_drain(to);
    n_checks++; if (to || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mismatch_beat_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mismatch_beat%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (frames_dropped !== 32'(exp_drop)) begin n_fail++; $display("FAIL mismatch_dropped: got %0d expected %0d", frames_dropped, exp_drop); end
    n_checks++; if (frames_ok !== 32'(exp_ok)) begin n_fail++; $display("FAIL mismatch_ok: got %0d expected %0d", frames_ok, exp_ok); end
  endtask

  task automatic test_bcast();
    int w; bit to;
    apply_reset();
    local_mac_addr = 48'h0A0B_0C0D_0E0F;
    send_frame(mk_frame(48'hFFFF_FFFF_FFFF, 48'hA1A2_A3A4_A5A6, 16'h0800, 8'h11, 2, 2, 8'h00), -1, w);
    wait_drain(to);
    n_checks++; if (frames_dropped !== 32'd1 || rx_q.size() != 0) begin n_fail++; $display("FAIL bcast_wrong_type: dropped %0d beats %0d expected 1 and 0", frames_dropped, rx_q.size()); end
    send_frame(mk_frame(48'hFFFF_FFFF_FFFF, 48'hB1B2_B3B4_B5B6, 16'h7400, 8'h22, 2, 2, 8'h00), -1, w);
    wait_drain(to);
    n_checks++; if (to || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bcast_beat_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bcast_beat%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (frames_ok !== 32'(exp_ok)) begin n_fail++; $display("FAIL bcast_ok: got %0d expected %0d", frames_ok, exp_ok); end
  endtask

  task automatic test_runts();
    int w; bit to;
    apply_reset();
    local_mac_addr = 48'h0A0B_0C0D_0E0F;
    send_frame(mk_frame(48'h0A0B_0C0D_0E0F, 48'h1122_3344_5566, 16'h7400, 8'h05, 1, 0, 8'h00), -1, w);
    send_frame(mk_frame(48'h0A0B_0C0D_0E0F, 48'h1122_3344_5566, 16'h7400, 8'h05, 2, 0, 8'h00), -1, w);
    wait_drain(to);
    n_checks++; if (frames_dropped !== 32'(exp_drop)) begin n_fail++; $display("FAIL runt_dropped: got %0d expected %0d", frames_dropped, exp_drop); end
    n_checks++; if (frames_ok !== 32'(exp_ok)) begin n_fail++; $display("FAIL runt_ok: got %0d expected %0d", frames_ok, exp_ok); end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL runt_out_beats: got %0d expected 0", rx_q.size()); end
  endtask

  task automatic test_back_to_back();
    int w, max_w; bit to; frame_t f;
    apply_reset();
    local_mac_addr = {$urandom(), 16'($urandom())};
    rnd_ready = 1'b1;
    max_w = 0;
    for (int n = 0; n < 100; n++) begin
      f = mk_frame(($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : local_mac_addr,
                   {$urandom(), 16'($urandom())}, 16'h7400, 8'($urandom()),
                   2, $urandom_range(1, 4), 8'h00);
      send_frame(f, -1, w);
      if (w > max_w) max_w = w;
    end
    wait_drain(to);
    rnd_ready = 1'b0;
    n_checks++; if (max_w != 0) begin n_fail++; $display("FAIL b2b_header_bubble: max wait %0d expected 0", max_w); end
    n_checks++; if (to || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_beat_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (frames_ok !== 32'd100) begin n_fail++; $display("FAIL b2b_frames_ok: got %0d expected 100", frames_ok); end
    n_checks++; if (frames_dropped !== 32'd0) begin n_fail++; $display("FAIL b2b_frames_dropped: got %0d expected 0", frames_dropped); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL b2b_hold_stable: %0d changes while stalled, expected 0", stall_viol); end
  endtask

  task automatic test_reset_midframe();
    int w; bit to;
    apply_reset();
    local_mac_addr = 48'h0A0B_0C0D_0E0F;
    send_frame(mk_frame(48'h0A0B_0C0D_0E0F, 48'h0102_0304_0506, 16'h7400, 8'h33, 2, 1, 8'h00), -1, w);
    send_frame(mk_frame(48'h0A0B_0C0D_0E01, 48'h0102_0304_0506, 16'h7400, 8'h33, 2, 1, 8'h00), -1, w);
    send_frame(mk_frame(48'h0A0B_0C0D_0E0F, 48'h7172_7374_7576, 16'h7400, 8'h44, 2, 4, 8'h00), 2, w);
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0", in_if.ready); end
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_if.valid); end
    n_checks++; if (frames_ok !== 32'd0 || frames_dropped !== 32'd0) begin n_fail++; $display("FAIL midrst_counters: got %0d/%0d expected 0/0", frames_ok, frames_dropped); end
    n_checks++; if (stream_out_dest !== 8'd0 || src_mac_addr !== 48'd0) begin n_fail++; $display("FAIL midrst_sideband: got %h/%h expected 0/0", stream_out_dest, src_mac_addr); end
    in_if.valid = 1'b0;
    apply_reset();
    send_frame(mk_frame(48'h0A0B_0C0D_0E0F, 48'h8182_8384_8586, 16'h7400, 8'h55, 2, 2, 8'h00), -1, w);
    wait_drain(to);
    n_checks++; if (to || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_beat_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_beat%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (frames_ok !== 32'd1) begin n_fail++; $display("FAIL midrst_frames_ok: got %0d expected 1", frames_ok); end
  endtask

  initial begin
    aresetn        = 1'b0;
    local_mac_addr = '0;
    in_if.data     = '0;
    in_if.keep     = '0;
    in_if.last     = 1'b0;
    in_if.valid    = 1'b0;
    out_if.ready   = 1'b1;
    test_reset();
    test_basic();
    test_mismatch();
    test_bcast();
    test_runts();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_header_rx.md
ETHERNET_HEADER_RX -- requirements
Module: ethernet_header_rx

Interface
REQ-001 The parameter ETHERTYPE SHALL default to 16'h7400 and set the only accepted ethertype.
REQ-002 The parameter ACCEPT_BCAST SHALL default to 1 and, when 1, also accept destination MAC 48'hFFFF_FFFF_FFFF.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock.
REQ-004 Port aresetn SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 Port local_mac_addr SHALL be an input, 48 bits wide, carrying this node's MAC address.
REQ-006 Ports stream_in_data/keep/last/valid SHALL be inputs of widths 64/8/1/1 carrying the inbound frame beats.
REQ-007 Port stream_in_ready SHALL be an output, 1 bit wide.
REQ-008 Ports stream_out_data/keep/last/valid SHALL be outputs of widths 64/8/1/1 carrying the payload beats.
REQ-009 Port stream_out_ready SHALL be an input, 1 bit wide.
REQ-010 Port stream_out_dest SHALL be an output, 8 bits wide, carrying the destination kernel byte from the header.
REQ-011 Port src_mac_addr SHALL be an output, 48 bits wide, carrying the sender MAC of the current frame.
REQ-012 Ports frames_ok and frames_dropped SHALL be outputs, 32 bits each, counting accepted and discarded frames.

Function
REQ-013 Wire byte k of each beat SHALL be data[8k+7:8k], first wire byte in data[7:0].
REQ-014 Beat 0 SHALL hold bytes 0-5 = dst MAC (MSB first) and bytes 6-7 = src MAC[47:32].
REQ-015 Beat 1 SHALL hold bytes 0-3 = src MAC[31:0], bytes 4-5 = ethertype (MSB first), byte 6 = dest and byte 7 = pad (ignored).
REQ-016 Beats 2 and later SHALL be payload and be forwarded unmodified, including keep and last.
REQ-017 The FSM states SHALL be HDR0, HDR1, PAYLOAD and DROP; the reset state SHALL be HDR0.
REQ-018 In HDR0, HDR1 and DROP, stream_in_ready SHALL be 1.
REQ-019 In PAYLOAD, stream_in_ready SHALL equal the output buffer's ready.
REQ-020 HDR0 on an accepted beat: latch dst MAC, src MAC[47:32] and a snapshot of local_mac_addr.
REQ-021 HDR0 on an accepted beat: last=1 or keep!=8'hFF SHALL count as dropped and go to HDR0 (if last) or DROP, else go to HDR1.
REQ-022 HDR1 on an accepted beat, match = (dst==snapshot OR (ACCEPT_BCAST AND dst==broadcast)) AND ethertype==ETHERTYPE AND keep==8'hFF.
REQ-023 HDR1, no match: increment frames_dropped, then go to HDR0 if last, else DROP.
REQ-024 HDR1, match with last=1 (header-only frame): increment frames_dropped and go to HDR0.
REQ-025 HDR1, match with last=0: latch dest and src MAC[31:0], then go to PAYLOAD.
REQ-026 PAYLOAD: each accepted beat SHALL be pushed to the output buffer; the beat with last=1 increments frames_ok and returns to HDR0.
REQ-027 DROP: beats SHALL be discarded until last=1 is accepted, then return to HDR0 (no further count).
REQ-028 The payload beat accepted in cycle N SHALL appear on stream_out in cycle N+1.
REQ-029 Sustained throughput SHALL be one beat per clock when stream_out_ready=1.
REQ-030 stream_out_* SHALL hold stable while valid=1 and ready=0.
REQ-031 stream_out_dest and src_mac_addr SHALL be valid with the first payload beat and held until the next accepted frame's first payload beat.
REQ-032 Counters SHALL wrap modulo 2^32.
REQ-033 A new frame's HDR0 beat SHALL be accepted in the cycle after the previous frame's last beat (no bubble).

Reset
REQ-034 On aresetn=0, immediately: state=HDR0, stream_out_valid=0, stream_in_ready=0.
REQ-035 On aresetn=0, immediately: counters=0, stream_out_dest=0, src_mac_addr=0, buffer emptied.
REQ-036 Reset mid-frame SHALL discard the frame without counting; the first beat after release is parsed as beat 0.
REQ-037 Upstream SHALL be reset jointly.

Structure
REQ-038 Package eth_pkg SHALL hold the state enum, ETHERTYPE_GALAPAGOS=16'h7400, MAC_BCAST and the header byte offsets.
REQ-039 The output register SHALL be sub-module axis_skid_buffer (2-entry, data/keep/last).
REQ-040 Sub-module axis_skid_buffer SHALL register ready with no combinational in-to-out ready path.

Verification
REQ-041 local=0x0A0B0C0D0E0F, frame dst=local, src=0x112233445566, type 0x7400, dest=0x05, payload 3 beats (last keep=8'h0F) -> 3 beats out unchanged, dest=0x05, src_mac=0x112233445566, frames_ok=1.
REQ-042 Same frame with dst=0x0A0B0C0D0E00 -> no output, frames_dropped=1, next valid frame accepted with no bubble.
REQ-043 dst=broadcast, ethertype 0x0800 -> dropped=1.
REQ-044 dst=broadcast, ethertype 0x7400 -> accepted.
REQ-045 Runt frames: last on beat 0, then last on beat 1 -> dropped=2, frames_ok=0, no out beats.
REQ-046 Random stream_out_ready (50%) over 100 back-to-back frames -> payload order and data preserved, no duplicates, frames_ok=100.
REQ-047 aresetn pulsed low during PAYLOAD beat 2 -> outputs and counters 0 immediately; following clean frame accepted, frames_ok=1.
